// File: rtl/result_transmitter.sv
// Sends one 7-byte result frame (header, four snapshot counts, winner, XOR checksum)
// over a valid/ready byte stream when a report is requested in result mode.
module result_transmitter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             report_req,
    input  logic [CNT_W-1:0] cand1_votes,
    input  logic [CNT_W-1:0] cand2_votes,
    input  logic [CNT_W-1:0] cand3_votes,
    input  logic [CNT_W-1:0] cand4_votes,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [2:0] LAST_IDX = 3'd6;

    state_t           state_q;
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] snap1_q, snap2_q, snap3_q, snap4_q;
    logic [7:0]       winner_q;
    logic [7:0]       csum_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic             busy_q;
    logic             frame_done_q;

    logic [7:0]       winner_d;
    logic [7:0]       csum_d;
    logic [2:0]       idx_d;

    // Ties for the maximum (including all-zero) report no winner.
    function automatic logic [7:0] winner_f(input logic [CNT_W-1:0] c1, input logic [CNT_W-1:0] c2,
                                            input logic [CNT_W-1:0] c3, input logic [CNT_W-1:0] c4);
        logic [CNT_W-1:0] max_v;
        logic [7:0]       idx_v;
        logic             tie_v;
        max_v = c1;
        idx_v = 8'd1;
        tie_v = 1'b0;
        if (c2 > max_v) begin
            max_v = c2; idx_v = 8'd2; tie_v = 1'b0;
        end else if (c2 == max_v) begin
            tie_v = 1'b1;
        end
        if (c3 > max_v) begin
            max_v = c3; idx_v = 8'd3; tie_v = 1'b0;
        end else if (c3 == max_v) begin
            tie_v = 1'b1;
        end
        if (c4 > max_v) begin
            idx_v = 8'd4; tie_v = 1'b0;
        end else if (c4 == max_v) begin
            tie_v = 1'b1;
        end
        return tie_v ? 8'h00 : idx_v;
    endfunction

    function automatic logic [7:0] checksum_f(input logic [7:0] b1, input logic [7:0] b2,
                                              input logic [7:0] b3, input logic [7:0] b4,
                                              input logic [7:0] b5);
        return HDR_BYTE ^ b1 ^ b2 ^ b3 ^ b4 ^ b5;
    endfunction

    function automatic logic [7:0] frame_byte_f(input logic [2:0] idx);
        case (idx)
            3'd0:    return HDR_BYTE;
            3'd1:    return 8'(snap1_q);
            3'd2:    return 8'(snap2_q);
            3'd3:    return 8'(snap3_q);
            3'd4:    return 8'(snap4_q);
            3'd5:    return winner_q;
            3'd6:    return csum_q;
            default: return 8'h00;
        endcase
    endfunction

    assign winner_d = winner_f(cand1_votes, cand2_votes, cand3_votes, cand4_votes);
    assign csum_d   = checksum_f(8'(cand1_votes), 8'(cand2_votes), 8'(cand3_votes),
                                 8'(cand4_votes), winner_d);
    assign idx_d    = idx_q + 3'd1;

    // Frame sequencer: snapshot on accept, step one byte per transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            snap1_q      <= '0;
            snap2_q      <= '0;
            snap3_q      <= '0;
            snap4_q      <= '0;
            winner_q     <= 8'h00;
            csum_q       <= 8'h00;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // The frame_done cycle is still the tail of the previous frame.
                    if (mode && report_req && !frame_done_q) begin
                        snap1_q    <= cand1_votes;
                        snap2_q    <= cand2_votes;
                        snap3_q    <= cand3_votes;
                        snap4_q    <= cand4_votes;
                        winner_q   <= winner_d;
                        csum_q     <= csum_d;
                        idx_q      <= 3'd0;
                        tx_data_q  <= HDR_BYTE;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SEND;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q        <= 3'd0;
                            tx_data_q    <= 8'h00;
                            tx_valid_q   <= 1'b0;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            idx_q     <= idx_d;
                            tx_data_q <= frame_byte_f(idx_d);
                        end
                    end else begin
                        state_q <= ST_SEND;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    idx_q      <= 3'd0;
                    tx_data_q  <= 8'h00;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_result_transmitter.sv
// Scoreboard bench for result_transmitter: expected frames are queued when a request
// is issued and compared byte-by-byte as the DUT transfers them.
module tb_result_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic       report_req = 1'b0;
    logic [7:0] cand1_votes = 8'd0, cand2_votes = 8'd0, cand3_votes = 8'd0, cand4_votes = 8'd0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       frame_done;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic       mon_en = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    result_transmitter #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .report_req(report_req),
        .cand1_votes(cand1_votes), .cand2_votes(cand2_votes),
        .cand3_votes(cand3_votes), .cand4_votes(cand4_votes),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent frame model: header, counts, winner, XOR checksum.
    task automatic push_frame(input logic [7:0] c1, input logic [7:0] c2,
                              input logic [7:0] c3, input logic [7:0] c4);
        logic [7:0] c[4];
        logic [7:0] mx;
        logic [7:0] win;
        int n;
        c[0] = c1; c[1] = c2; c[2] = c3; c[3] = c4;
        mx = 8'd0;
        for (int i = 0; i < 4; i++) if (c[i] > mx) mx = c[i];
        n = 0; win = 8'h00;
        for (int i = 0; i < 4; i++) if (c[i] == mx) begin n++; win = 8'(i + 1); end
        if (n != 1) win = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) exp_q.push_back(c[i]);
        exp_q.push_back(win);
        exp_q.push_back(8'hA5 ^ c1 ^ c2 ^ c3 ^ c4 ^ win);
    endtask

    // Monitor: scoreboard pops on transfers, idle-data and backpressure-hold checks.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, tx_valid}, 32'd1);
                chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                else chk("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            if (!tx_valid) chk("idle_data", {24'd0, tx_data}, 32'd0);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_req(input logic [7:0] c1, input logic [7:0] c2,
                             input logic [7:0] c3, input logic [7:0] c4);
        cand1_votes = c1; cand2_votes = c2; cand3_votes = c3; cand4_votes = c4;
        mode = 1'b1;
        report_req = 1'b1;
        push_frame(c1, c2, c3, c4);
        @(posedge clk); #1;
        report_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_valid);
        int nvalid = 0;
        logic seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (frame_done) begin seen = 1'b1; break; end
            if (tx_valid) nvalid++;
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_valid_cycles"}, nvalid, exp_valid);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk({tag, "_valid"}, {31'd0, tx_valid}, 32'd0);
            chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, "_done"}, {31'd0, frame_done}, 32'd0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        @(posedge clk); #1;

        // Basic frame, then first-byte latency
        start_req(8'd5, 8'd1, 8'd0, 8'd2);
        @(negedge clk);
        chk("lat_valid", {31'd0, tx_valid}, 32'd1);
        chk("lat_data", {24'd0, tx_data}, 32'hA5);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        wait_done("basic", 6);
        @(posedge clk); #1;

        // Tie for max: no winner
        start_req(8'd3, 8'd7, 8'd2, 8'd7);
        wait_done("tie", 7);
        @(posedge clk); #1;

        // All-zero counts and a clear winner in slot 4
        start_req(8'd0, 8'd0, 8'd0, 8'd0);
        wait_done("zero", 7);
        @(posedge clk); #1;
        start_req(8'd10, 8'd20, 8'd30, 8'd255);
        wait_done("win4", 7);
        @(posedge clk); #1;

        // Backpressure for 5 cycles on byte 2
        start_req(8'd5, 8'd1, 8'd0, 8'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_data", {24'd0, tx_data}, 32'h01);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_done("bp", 5);
        @(posedge clk); #1;

        // mode=0 requests ignored
        mode = 1'b0;
        report_req = 1'b1;
        quiet("mode0", 6);
        @(posedge clk); #1;
        report_req = 1'b0;

        // Requests during SEND ignored
        start_req(8'd1, 8'd2, 8'd3, 8'd4);
        report_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        report_req = 1'b0;
        wait_done("midreq", 5);
        quiet("midreq_after", 10);
        @(posedge clk); #1;

        // Request in the frame_done cycle ignored
        start_req(8'd9, 8'd4, 8'd4, 8'd1);
        repeat (7) @(posedge clk);
        #1;
        report_req = 1'b1;
        @(posedge clk); #1;
        report_req = 1'b0;
        quiet("donereq", 10);
        chk("donereq_queue", exp_q.size(), 32'd0);
        @(posedge clk); #1;

        // Count changes after acceptance don't affect the frame
        start_req(8'd5, 8'd1, 8'd0, 8'd2);
        cand1_votes = 8'd9; cand2_votes = 8'd9; cand3_votes = 8'd9; cand4_votes = 8'd9;
        mode = 1'b0;
        wait_done("snap", 7);
        @(posedge clk); #1;

        // Reset during byte 3 aborts the frame
        start_req(8'd5, 8'd1, 8'd0, 8'd2);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", {31'd0, tx_valid}, 32'd0);
        chk("abort_data", {24'd0, tx_data}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, frame_done}, 32'd0);
        quiet("abort_after", 8);
        @(posedge clk); #1;
        start_req(8'd5, 8'd1, 8'd0, 8'd2);
        wait_done("restart", 7);

        chk("final_queue", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_transmitter.md
RESULT_TRANSMITTER -- requirements
Module: result_transmitter

Interface
REQ-001 SHALL have parameter: CNT_W, default 8, per-candidate vote count width; frame bytes are 8 bits and only CNT_W=8 is supported.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: mode  input  1  0=voting, 1=result; a frame starts only when mode=1.
REQ-005 SHALL have port: report_req  input  1  request to send one result frame; sampled each cycle.
REQ-006 SHALL have ports: cand1_votes, cand2_votes, cand3_votes, cand4_votes  input  CNT_W each  live vote counts from the vote logger.
REQ-007 SHALL have port: tx_data  output  8  current frame byte.
REQ-008 SHALL have port: tx_valid  output  1  tx_data is valid.
REQ-009 SHALL have port: tx_ready  input  1  sink accepts the byte; a byte transfers on a cycle with tx_valid=1 and tx_ready=1.
REQ-010 SHALL have port: busy  output  1  high from request acceptance until the last byte transfers.
REQ-011 SHALL have port: frame_done  output  1  one-cycle pulse after the last byte transfers.

Function
REQ-012 SHALL implement FSM states IDLE and SEND; all outputs registered.
REQ-013 IDLE: report_req=1 and mode=1 on an edge -> accept; snapshot all four counts; go to SEND; byte index=0.
REQ-014 Accept cycle N -> tx_valid=1, tx_data=0xA5, busy=1 from N+1.
REQ-015 Frame, 7 bytes in order: 0xA5, cand1, cand2, cand3, cand4, winner, checksum.
REQ-016 Winner byte = candidate number 1..4 with the strictly greatest unsigned snapshot count; two or more candidates sharing the maximum, including all zero -> 0x00.
REQ-017 Checksum = 8-bit XOR of frame bytes 0..5.
REQ-018 Frame bytes come only from the snapshot; count changes after acceptance have no effect on the current frame.
REQ-019 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL hold stable.
REQ-020 Transfer of byte k<6 -> byte k+1 presented on the next cycle with tx_valid kept high; with tx_ready=1 continuously the frame takes 7 consecutive cycles.
REQ-021 Transfer of byte 6 -> next cycle: tx_valid=0, busy=0, frame_done=1 for one cycle, state=IDLE.
REQ-022 report_req during SEND, or in the frame_done cycle before the IDLE edge, SHALL be ignored; requests are not queued.
REQ-023 report_req with mode=0 SHALL be ignored.
REQ-024 Once accepted, a frame SHALL complete regardless of mode changes.
REQ-025 tx_data SHALL be 0x00 whenever tx_valid=0.

Reset
REQ-026 rst=1 at an edge -> next cycle: state=IDLE, tx_valid=0, tx_data=0x00, busy=0, frame_done=0, byte index=0, snapshot=0.
REQ-027 rst SHALL take priority over all other inputs, including mid-frame; the aborted frame is discarded with no frame_done.

Verification
REQ-028 Counts 5,1,0,2; mode=1; one-cycle report_req; tx_ready=1 -> bytes A5,05,01,00,02,01,A2 on 7 consecutive cycles; then frame_done=1 for one cycle.
REQ-029 Counts 3,7,2,7 -> winner byte 00, checksum A4.
REQ-030 Backpressure: tx_ready=0 for 5 cycles during byte 2 -> tx_data holds at cand2 with tx_valid=1; frame otherwise identical.
REQ-031 mode=0 with report_req=1 -> tx_valid stays 0 and busy stays 0; report_req pulsed during a frame -> exactly one frame is sent.
REQ-032 Counts changed after acceptance from 5,1,0,2 to 9,9,9,9 -> transmitted bytes still match the 5,1,0,2 snapshot.
REQ-033 rst asserted during byte 3 -> next cycle all outputs 0 and no frame_done; a new request then sends a full frame starting 0xA5.
